// File: rtl/div_if.sv
// Handshake and data bundle between the EX stage and the divide sequencer.
interface div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op_signed;
    logic             op_rem;
    logic             flush;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             stall_EX;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    // EX-stage control side
    modport master (
        output start, op_signed, op_rem, flush, a, b,
        input  stall_EX, busy, done, result
    );

    // Divider side
    modport slave (
        input  start, op_signed, op_rem, flush, a, b,
        output stall_EX, busy, done, result
    );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle, followed by a sign-fixup cycle and a one-cycle
// DONE pulse. Divide-by-zero and signed overflow bypass the iteration.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    div_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;      // partial remainder (magnitude)
    logic [WIDTH-1:0] quo_q, quo_d;      // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] div_q, div_d;      // divisor magnitude
    logic             sa_q, sa_d;        // sign of dividend
    logic             sb_q, sb_d;        // sign of divisor
    logic             signed_q, signed_d;
    logic             oprem_q, oprem_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic             accept;
    logic             is_ovf;

    // Next-state, datapath and special-case decode
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        signed_d = signed_q;
        oprem_d  = oprem_q;
        result_d = result_q;

        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, div_q};
        q_fix  = (signed_q && (sa_q != sb_q)) ? -quo_q : quo_q;
        r_fix  = (signed_q && sa_q) ? -rem_q : rem_q;
        accept = bus.start && !bus.flush;
        is_ovf = bus.op_signed && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sa_d     = bus.a[WIDTH-1];
                    sb_d     = bus.b[WIDTH-1];
                    signed_d = bus.op_signed;
                    oprem_d  = bus.op_rem;
                    if (bus.b == '0) begin
                        result_d = bus.op_rem ? bus.a : '1;
                        state_d  = S_DONE;
                    end else if (is_ovf) begin
                        result_d = bus.op_rem ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
                        state_d  = S_DONE;
                    end else begin
                        div_d   = (bus.op_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
                        quo_d   = (bus.op_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
                        rem_d   = '0;
                        cnt_d   = CW'(WIDTH);
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // diff[WIDTH] is the borrow: clear means rem_sh >= divisor
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = oprem_q ? r_fix : q_fix;
                state_d  = S_DONE;
            end
            S_DONE: begin
                // start is still the same held instruction; never re-arm here
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // An aborted instruction must leave result untouched
        if (bus.flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            signed_q <= 1'b0;
            oprem_q  <= 1'b0;
            result_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            signed_q <= signed_d;
            oprem_q  <= oprem_d;
            result_q <= result_d;
        end
    end

    // Acceptance cycle stalls combinationally; busy/done decode registered state
    always_comb begin
        bus.stall_EX = (bus.start && (state_q == S_IDLE) && !bus.flush)
                     || (state_q == S_RUN) || (state_q == S_FIX);
        bus.busy     = (state_q == S_RUN) || (state_q == S_FIX);
        bus.done     = (state_q == S_DONE) && !bus.flush;
        bus.result   = result_q;
    end
endmodule

// File: tb/tb_div_seq.sv
// Directed-vector bench for div_seq: latency, stall window, signed fixup,
// special cases, flush abort and asynchronous reset.
module tb_div_seq;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    div_if #(.WIDTH(32)) bus ();

    div_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op with start held through DONE; check result, latency, stall window
    task automatic run_op(input string tag, input logic s, input logic r,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp, input int exp_lat);
        int cyc;
        int stall_cnt;
        logic seen;
        @(negedge clk);
        bus.op_signed = s;
        bus.op_rem    = r;
        bus.a         = av;
        bus.b         = bv;
        bus.start     = 1'b1;
        #1;
        check({tag, " stall_c0"}, 32'(bus.stall_EX), 32'd1);
        cyc       = 0;
        stall_cnt = 1;
        seen      = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.done) seen = 1'b1;
            else if (bus.stall_EX) stall_cnt++;
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " done_cycle"}, 32'(cyc), 32'(exp_lat));
        check({tag, " stall_cycles"}, 32'(stall_cnt), 32'(exp_lat));
        check({tag, " stall_in_done"}, 32'(bus.stall_EX), 32'd0);
        check({tag, " result"}, bus.result, exp);
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        check({tag, " single_done"}, 32'(bus.done), 32'd0);
        check({tag, " result_hold"}, bus.result, exp);
    endtask

    initial begin
        n_vec        = 0;
        n_miss       = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.op_signed = 1'b0;
        bus.op_rem   = 1'b0;
        bus.flush    = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        #12;
        check("rst stall", 32'(bus.stall_EX), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("divu 100/7", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 34);
        run_op("remu 100/7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 34);
        run_op("div -7/2",   1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_op("rem -7/2",   1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("rem 7/-2",   1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
        run_op("div min/2",  1'b1, 1'b0, 32'h8000_0000, 32'd2, 32'hC000_0000, 34);

        // Flush in RUN cycle 10
        @(negedge clk);
        bus.op_signed = 1'b0;
        bus.op_rem    = 1'b0;
        bus.a         = 32'd50;
        bus.b         = 32'd5;
        bus.start     = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check("flush no_done_run", 32'(bus.done), 32'd0);
        end
        check("flush busy_c10", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("flush done", 32'(bus.done), 32'd0);
        check("flush stall", 32'(bus.stall_EX), 32'd0);
        check("flush busy", 32'(bus.busy), 32'd0);
        check("flush result_held", bus.result, 32'hC000_0000);
        run_op("divu 9/3 after flush", 1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 34);

        run_op("divu 5/0",   1'b0, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu 5/0",   1'b0, 1'b1, 32'd5, 32'd0, 32'd5, 1);
        run_op("div -7/0",   1'b1, 1'b0, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("div ovf",    1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem ovf",    1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("divu max/1", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
        run_op("divu min/m1", 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);

        // Reset in RUN cycle 20
        @(negedge clk);
        bus.op_signed = 1'b0;
        bus.op_rem    = 1'b0;
        bus.a         = 32'd1000;
        bus.b         = 32'd10;
        bus.start     = 1'b1;
        for (int i = 1; i <= 20; i++) @(negedge clk);
        check("pre_rst busy", 32'(bus.busy), 32'd1);
        rst_n     = 1'b0;
        bus.start = 1'b0;
        #1;
        check("mid_rst stall", 32'(bus.stall_EX), 32'd0);
        check("mid_rst busy", 32'(bus.busy), 32'd0);
        check("mid_rst done", 32'(bus.done), 32'd0);
        check("mid_rst result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("divu 100/7 post_rst", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 34);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
